instr_fetch_queue: RTL

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

---
 rtl/instr_fetch_queue.sv | 105 ++++++++++
 1 files changed

// File: rtl/instr_fetch_queue.sv
// Dual-slot instruction fetch queue: a circular buffer that accepts up to two entries per cycle and presents the two oldest to decode.
// Entries are visible one cycle after acceptance; in_ready drops when fewer than two slots are free, and the sender holds its data until then.
module instr_fetch_queue #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [1:0]               in_valid,
    input  logic [31:0]              in_vaddr0,
    input  logic [31:0]              in_vaddr1,
    input  logic [31:0]              in_instr0,
    input  logic [31:0]              in_instr1,
    output logic                     in_ready,
    output logic [1:0]               out_valid,
    output logic [31:0]              out_vaddr0,
    output logic [31:0]              out_vaddr1,
    output logic [31:0]              out_instr0,
    output logic [31:0]              out_instr1,
    input  logic [1:0]               out_pop,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0] vaddr;
        logic [31:0] instr;
    } entry_t;

    entry_t        r_mem [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic [CW-1:0] w_free;
    logic [1:0]    w_push_n;
    logic [1:0]    w_pop_req;
    logic [1:0]    w_pop_n;
    logic [AW-1:0] w_head1;
    logic [AW-1:0] w_tail1;

    always_comb begin
        w_free   = CW'(DEPTH) - r_count;
        in_ready = (w_free >= CW'(2));

        // Illegal slot patterns (2'b10) count as no transfer.
        w_push_n = 2'd0;
        if (in_ready) begin
            case (in_valid)
                2'b01:   w_push_n = 2'd1;
                2'b11:   w_push_n = 2'd2;
                default: w_push_n = 2'd0;
            endcase
        end

        case (out_pop)
            2'b01:   w_pop_req = 2'd1;
            2'b11:   w_pop_req = 2'd2;
            default: w_pop_req = 2'd0;
        endcase
        w_pop_n = (CW'(w_pop_req) > r_count) ? r_count[1:0] : w_pop_req;

        w_head1 = r_head + AW'(1);
        w_tail1 = r_tail + AW'(1);
    end

    assign out_valid[0] = (r_count != '0);
    assign out_valid[1] = (r_count >= CW'(2));
    assign out_vaddr0   = r_mem[r_head].vaddr;
    assign out_instr0   = r_mem[r_head].instr;
    assign out_vaddr1   = r_mem[w_head1].vaddr;
    assign out_instr1   = r_mem[w_head1].instr;
    assign count        = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + AW'(w_pop_n);
            r_tail  <= r_tail + AW'(w_push_n);
            r_count <= r_count + CW'(w_push_n) - CW'(w_pop_n);
        end
    end

    // Storage has no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            if (w_push_n != 2'd0) begin
                r_mem[r_tail] <= '{vaddr: in_vaddr0, instr: in_instr0};
            end
            if (w_push_n == 2'd2) begin
                r_mem[w_tail1] <= '{vaddr: in_vaddr1, instr: in_instr1};
            end
        end
    end

endmodule
